// File: rtl/pixel_command_engine_pkg.sv
`default_nettype none
// Shared opcodes, FSM state encoding and argument-byte layout for the
// UART-fed pixel command engine.
package pixel_command_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARGS   = 2'd1,
    ST_RUN    = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_FILL  = 8'h01;
  localparam logic [7:0] OP_FRAME = 8'h04;
  localparam logic [7:0] OP_RECT  = 8'h06;

  // RECT argument bytes occupy indices 0..10; FILL reuses the colour tail (8..10).
  localparam logic [3:0] ARG_BYTES_FILL = 4'd3;
  localparam logic [3:0] ARG_BYTES_RECT = 4'd11;
  localparam logic [3:0] ARG_IDX_FILL   = ARG_BYTES_RECT - ARG_BYTES_FILL;
  localparam logic [3:0] ARG_IDX_LAST   = ARG_BYTES_RECT - 4'd1;

  // Starting row base for a rectangle: shift-add of the constant row width.
  function automatic logic [31:0] row_base(input logic [15:0] row, input logic [31:0] width);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (row[i]) acc = acc + (width << i);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_command_engine_rect_scanner.sv
`default_nettype none
// Raster-walks a rectangle row-major, reporting the current pixel's linear
// address and whether it falls inside the framebuffer.
module pixel_command_engine_rect_scanner
  import pixel_command_engine_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  advance_i,
  input  logic [15:0]           x0_i,
  input  logic [15:0]           y0_i,
  input  logic [15:0]           w_i,
  input  logic [15:0]           h_i,
  output logic                  active_o,
  output logic                  in_range_o,
  output logic                  last_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam logic [16:0]           H_LIM    = 17'(H_RES);
  localparam logic [16:0]           V_LIM    = 17'(V_RES);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(H_RES);

  logic                  active_q, active_d;
  logic [15:0]           x_q, x_d, y_q, y_d, xs_q, xs_d;
  logic [16:0]           xe_q, xe_d, ye_q, ye_d;
  logic [ADDR_WIDTH-1:0] rb_q, rb_d;
  logic [16:0]           x_nx, y_nx;

  assign x_nx       = {1'b0, x_q} + 17'd1;
  assign y_nx       = {1'b0, y_q} + 17'd1;
  assign active_o   = active_q;
  assign in_range_o = active_q && ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
  assign last_o     = (x_nx >= xe_q) && (y_nx >= ye_q);
  assign addr_o     = rb_q + ADDR_WIDTH'(x_q);

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    xs_d     = xs_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    rb_d     = rb_q;
    if (start_i) begin
      active_d = (w_i != 16'd0) && (h_i != 16'd0);
      x_d      = x0_i;
      y_d      = y0_i;
      xs_d     = x0_i;
      // 17-bit ends so x0+w and y0+h never wrap
      xe_d     = {1'b0, x0_i} + {1'b0, w_i};
      ye_d     = {1'b0, y0_i} + {1'b0, h_i};
      rb_d     = ADDR_WIDTH'(row_base(y0_i, 32'(H_RES)));
    end else if (active_q && advance_i) begin
      if (x_nx < xe_q) begin
        x_d = x_q + 16'd1;
      end else if (y_nx < ye_q) begin
        x_d  = xs_q;
        y_d  = y_q + 16'd1;
        rb_d = rb_q + ROW_STEP;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      rb_q     <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xs_q     <= xs_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      rb_q     <= rb_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_command_engine.sv
`default_nettype none
// Byte-level command decoder (NOP/FILL/FRAME/RECT) that turns a UART byte
// stream into valid/ready framebuffer writes.
module pixel_command_engine
  import pixel_command_engine_pkg::*;
#(
  parameter int CHANNEL_BITS = 4,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic                      i_Rx_DV,
  input  logic [7:0]                i_Rx_Byte,
  output logic                      o_Write_Valid,
  input  logic                      i_Write_Ready,
  output logic [ADDR_WIDTH-1:0]     o_Write_Addr,
  output logic [3*CHANNEL_BITS-1:0] o_Write_Data,
  output logic                      o_Busy,
  output logic                      o_Error,
  output logic                      o_Overrun
);

  localparam int                    BPP       = 3 * CHANNEL_BITS;
  localparam int                    NPIX      = H_RES * V_RES;
  localparam logic [ADDR_WIDTH:0]   PIX_COUNT = (ADDR_WIDTH + 1)'(NPIX);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

  state_t                  state_q, state_d;
  logic                    is_rect_q, is_rect_d;
  logic [3:0]              arg_idx_q, arg_idx_d;
  logic [15:0]             x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [CHANNEL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [1:0]              sbyte_q, sbyte_d;
  logic [CHANNEL_BITS-1:0] sr_q, sr_d, sg_q, sg_d;
  logic                    svalid_q, svalid_d;
  logic [ADDR_WIDTH-1:0]   saddr_q, saddr_d;
  logic [BPP-1:0]          sdata_q, sdata_d;
  logic [ADDR_WIDTH:0]     snext_q, snext_d;
  logic                    error_q, error_d, overrun_q, overrun_d;

  logic [CHANNEL_BITS-1:0] chan;
  logic                    scan_start, scan_adv, scan_active, scan_in_range, scan_last;
  logic [ADDR_WIDTH-1:0]   scan_addr;
  logic                    run_step;

  assign chan      = i_Rx_Byte[7 -: CHANNEL_BITS];
  // Out-of-range pixels are skipped at one per cycle regardless of Ready.
  assign run_step  = scan_in_range ? i_Write_Ready : 1'b1;
  assign scan_adv  = (state_q == ST_RUN) && run_step;

  pixel_command_engine_rect_scanner #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scanner (
    .clk_i      (i_Clock),
    .rst_ni     (i_Reset_n),
    .start_i    (scan_start),
    .advance_i  (scan_adv),
    .x0_i       (is_rect_q ? x0_q : 16'd0),
    .y0_i       (is_rect_q ? y0_q : 16'd0),
    .w_i        (is_rect_q ? w_q  : 16'(H_RES)),
    .h_i        (is_rect_q ? h_q  : 16'(V_RES)),
    .active_o   (scan_active),
    .in_range_o (scan_in_range),
    .last_o     (scan_last),
    .addr_o     (scan_addr)
  );

  always_comb begin
    state_d    = state_q;
    is_rect_d  = is_rect_q;
    arg_idx_d  = arg_idx_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    sbyte_d    = sbyte_q;
    sr_d       = sr_q;
    sg_d       = sg_q;
    svalid_d   = svalid_q;
    saddr_d    = saddr_q;
    sdata_d    = sdata_q;
    snext_d    = snext_q;
    error_d    = 1'b0;
    overrun_d  = 1'b0;
    scan_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV) begin
          unique case (i_Rx_Byte)
            OP_NOP: ;
            OP_FILL: begin
              state_d   = ST_ARGS;
              is_rect_d = 1'b0;
              arg_idx_d = ARG_IDX_FILL;
            end
            OP_RECT: begin
              state_d   = ST_ARGS;
              is_rect_d = 1'b1;
              arg_idx_d = 4'd0;
            end
            OP_FRAME: begin
              state_d  = ST_STREAM;
              sbyte_d  = 2'd0;
              svalid_d = 1'b0;
              snext_d  = '0;
            end
            default: error_d = 1'b1;
          endcase
        end
      end

      ST_ARGS: begin
        if (i_Rx_DV) begin
          arg_idx_d = arg_idx_q + 4'd1;
          unique case (arg_idx_q)
            4'd0:    x0_d[15:8] = i_Rx_Byte;
            4'd1:    x0_d[7:0]  = i_Rx_Byte;
            4'd2:    y0_d[15:8] = i_Rx_Byte;
            4'd3:    y0_d[7:0]  = i_Rx_Byte;
            4'd4:    w_d[15:8]  = i_Rx_Byte;
            4'd5:    w_d[7:0]   = i_Rx_Byte;
            4'd6:    h_d[15:8]  = i_Rx_Byte;
            4'd7:    h_d[7:0]   = i_Rx_Byte;
            4'd8:    r_d        = chan;
            4'd9:    g_d        = chan;
            ARG_IDX_LAST: begin
              b_d        = chan;
              scan_start = 1'b1;
              state_d    = ST_RUN;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_RUN: begin
        if (i_Rx_DV) overrun_d = 1'b1;
        if (!scan_active || (scan_last && run_step)) state_d = ST_IDLE;
      end

      ST_STREAM: begin
        if (svalid_q && i_Write_Ready) begin
          svalid_d = 1'b0;
          if (saddr_q == LAST_ADDR) state_d = ST_IDLE;
        end
        if (i_Rx_DV) begin
          unique case (sbyte_q)
            2'd0: begin
              sr_d    = chan;
              sbyte_d = 2'd1;
            end
            2'd1: begin
              sg_d    = chan;
              sbyte_d = 2'd2;
            end
            default: begin
              sbyte_d = 2'd0;
              // A pixel arriving while the previous write is still pending is lost.
              if ((svalid_q && !i_Write_Ready) || (snext_q == PIX_COUNT)) begin
                overrun_d = 1'b1;
              end else begin
                svalid_d = 1'b1;
                saddr_d  = snext_q[ADDR_WIDTH-1:0];
                sdata_d  = {chan, sg_q, sr_q};
                snext_d  = snext_q + 1'b1;
              end
            end
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      is_rect_q <= 1'b0;
      arg_idx_q <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      sbyte_q   <= '0;
      sr_q      <= '0;
      sg_q      <= '0;
      svalid_q  <= 1'b0;
      saddr_q   <= '0;
      sdata_q   <= '0;
      snext_q   <= '0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_rect_q <= is_rect_d;
      arg_idx_q <= arg_idx_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      sbyte_q   <= sbyte_d;
      sr_q      <= sr_d;
      sg_q      <= sg_d;
      svalid_q  <= svalid_d;
      saddr_q   <= saddr_d;
      sdata_q   <= sdata_d;
      snext_q   <= snext_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    o_Write_Valid = 1'b0;
    o_Write_Addr  = '0;
    o_Write_Data  = '0;
    if (state_q == ST_RUN && scan_in_range) begin
      o_Write_Valid = 1'b1;
      o_Write_Addr  = scan_addr;
      o_Write_Data  = {b_q, g_q, r_q};
    end else if (state_q == ST_STREAM && svalid_q) begin
      o_Write_Valid = 1'b1;
      o_Write_Addr  = saddr_q;
      o_Write_Data  = sdata_q;
    end
  end

  assign o_Busy    = (state_q != ST_IDLE);
  assign o_Error   = error_q;
  assign o_Overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_command_engine.sv
`default_nettype none
// Randomised scoreboard bench for pixel_command_engine on an 8x4 framebuffer.
module tb_pixel_command_engine;

  localparam int CB  = 4;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int AW  = 5;
  localparam int BPP = 3 * CB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx_dv = 1'b0;
  logic [7:0]     rx_byte = 8'h00;
  logic           ready = 1'b0;
  logic           valid, busy, error, overrun;
  logic [AW-1:0]  addr;
  logic [BPP-1:0] data;

  always #5 clk = ~clk;

  pixel_command_engine #(
    .CHANNEL_BITS (CB),
    .H_RES        (H),
    .V_RES        (V),
    .ADDR_WIDTH   (AW)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Write_Valid (valid),
    .i_Write_Ready (ready),
    .o_Write_Addr  (addr),
    .o_Write_Data  (data),
    .o_Busy        (busy),
    .o_Error       (error),
    .o_Overrun     (overrun)
  );

  typedef struct packed {
    logic [AW-1:0]  a;
    logic [BPP-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  n_writes = 0;
  int  n_err = 0;
  int  n_ov = 0;
  int  ready_mode = 0;   // 0 always, 1 random, 2 one-in-three, 3 never
  int  rcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Ready generator, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(0, 1) == 1);
      2: begin
        rcnt  = (rcnt + 1) % 3;
        ready = (rcnt == 0);
      end
      default: ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted write, checks hold while stalled.
  initial begin
    logic                stall;
    logic [AW+BPP-1:0]   stall_v;
    wr_t                 e;
    stall = 1'b0;
    stall_v = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_hold", 32'({addr, data}), 32'(stall_v));
      end
      if (valid && ready) begin
        n_writes++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h, required no write", addr, data);
        end else begin
          e = sb.pop_front();
          check("write_addr", 32'(addr), 32'(e.a));
          check("write_data", 32'(data), 32'(e.d));
        end
      end else if (!valid) begin
        check("idle_zero", 32'({addr, data}), 32'd0);
      end
      stall   = valid && !ready;
      stall_v = {addr, data};
      if (error)   n_err++;
      if (overrun) n_ov++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [BPP-1:0] colour(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {b[7:4], g[7:4], r[7:4]};
  endfunction

  // Reference: every in-frame pixel of the rectangle, row-major.
  task automatic model_rect(input int x0, input int y0, input int w, input int h, input logic [BPP-1:0] d);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x < H && y < V) sb.push_back(wr_t'{a: AW'(y * H + x), d: d});
  endtask

  task automatic do_fill(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    model_rect(0, 0, H, V, colour(r, g, b));
    send_byte(8'h01, 0);
    send_byte(r, 0);
    send_byte(g, 0);
    send_byte(b, 0);
  endtask

  task automatic do_rect(input int x0, input int y0, input int w, input int h,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [15:0] f[4];
    f[0] = 16'(x0);
    f[1] = 16'(y0);
    f[2] = 16'(w);
    f[3] = 16'(h);
    model_rect(x0, y0, w, h, colour(r, g, b));
    send_byte(8'h06, 0);
    for (int i = 0; i < 4; i++) begin
      send_byte(f[i][15:8], 0);
      send_byte(f[i][7:0], 0);
    end
    send_byte(r, 0);
    send_byte(g, 0);
    send_byte(b, 0);
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int gap);
    send_byte(r, gap);
    send_byte(g, gap);
    send_byte(b, gap);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_idle"}, 32'(cyc < 5000), 32'd1);
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
  endtask

  initial begin
    int            w0, e0, o0;
    logic [7:0]    r, g, b;
    logic [BPP-1:0] px0;

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_addr_data", 32'({addr, data}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // FILL with Ready always high; first write the cycle after the last argument.
    ready_mode = 0;
    tick();
    w0 = n_writes;
    do_fill(8'hF0, 8'h0F, 8'hA5);
    @(negedge clk);
    check("fill_first_valid", 32'(valid), 32'd1);
    check("fill_first_addr", 32'(addr), 32'd0);
    check("fill_first_data", 32'(data), 32'h A0F);
    wait_idle("fill");
    check("fill_count", 32'(n_writes - w0), 32'd32);

    // Clipped rectangle: only (6..7, 2..3) lands in frame.
    w0 = n_writes;
    do_rect(6, 2, 4, 3, 8'h12, 8'h34, 8'h56);
    wait_idle("rect_clip");
    check("rect_clip_count", 32'(n_writes - w0), 32'd4);

    // Degenerate and fully off-screen rectangles (exercises the high byte).
    w0 = n_writes;
    do_rect(1, 1, 0, 3, 8'hFF, 8'hFF, 8'hFF);
    wait_idle("rect_w0");
    do_rect(2, 1, 3, 0, 8'hFF, 8'hFF, 8'hFF);
    wait_idle("rect_h0");
    do_rect(256, 0, 2, 2, 8'hFF, 8'hFF, 8'hFF);
    wait_idle("rect_far");
    check("rect_empty_count", 32'(n_writes - w0), 32'd0);

    // Random rectangles under random backpressure.
    ready_mode = 1;
    for (int k = 0; k < 10; k++) begin
      do_rect($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
              8'($urandom), 8'($urandom), 8'($urandom));
      wait_idle("rect_rand");
    end

    // Byte arriving during RUN is dropped with an overrun pulse.
    ready_mode = 3;
    tick();
    tick();
    do_fill(8'($urandom), 8'($urandom), 8'($urandom));
    tick();
    o0 = n_ov;
    send_byte(8'h55, 3);
    check("run_overrun", 32'(n_ov - o0), 32'd1);
    ready_mode = 0;
    wait_idle("fill_stalled");

    // FRAME with Ready high one cycle in three; bytes slow enough that nothing drops.
    ready_mode = 2;
    tick();
    o0 = n_ov;
    send_byte(8'h04, 2);
    for (int p = 0; p < H * V; p++) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      sb.push_back(wr_t'{a: AW'(p), d: colour(r, g, b)});
      send_pixel(r, g, b, 3);
    end
    wait_idle("frame_slow");
    check("frame_slow_overrun", 32'(n_ov - o0), 32'd0);

    // FRAME with Ready low for four back-to-back pixels: three drop, address holds at 0.
    ready_mode = 3;
    tick();
    tick();
    o0 = n_ov;
    send_byte(8'h04, 0);
    for (int p = 0; p < 4; p++) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      if (p == 0) begin
        px0 = colour(r, g, b);
        sb.push_back(wr_t'{a: AW'(0), d: px0});
      end
      send_pixel(r, g, b, 0);
    end
    repeat (3) tick();
    check("frame_drop_overrun", 32'(n_ov - o0), 32'd3);
    @(negedge clk);
    check("frame_held_addr", 32'(addr), 32'd0);
    check("frame_held_data", 32'(data), 32'(px0));
    ready_mode = 0;
    tick();
    for (int p = 1; p < H * V; p++) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      sb.push_back(wr_t'{a: AW'(p), d: colour(r, g, b)});
      send_pixel(r, g, b, 3);
    end
    wait_idle("frame_drop");
    check("frame_drop_overrun_total", 32'(n_ov - o0), 32'd3);

    // Unknown opcode flags an error and leaves the engine idle; NOP is then accepted.
    e0 = n_err;
    w0 = n_writes;
    send_byte(8'h07, 3);
    check("bad_op_error", 32'(n_err - e0), 32'd1);
    check("bad_op_busy", 32'(busy), 32'd0);
    send_byte(8'h00, 0);
    check("nop_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    check("nop_no_error", 32'(n_err - e0), 32'd1);
    check("bad_op_writes", 32'(n_writes - w0), 32'd0);

    // Asynchronous reset in the middle of a FILL.
    do_fill(8'h80, 8'h40, 8'h20);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    w0 = n_writes;
    do_fill(8'h33, 8'h66, 8'h99);
    @(negedge clk);
    check("refill_first_addr", 32'(addr), 32'd0);
    wait_idle("refill");
    check("refill_count", 32'(n_writes - w0), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
